uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Synchronous byte FIFO feeding the UART transmitter. Client logic pushes bytes on the write port.
//   The TX engine pops them on the read port: it pulses rd_en_i and captures rd_data_o one clock later.
//   Provides level/almost-full status for client flow control and sticky overflow/underflow error flags.
// PARAMETERS
//   DATA_WIDTH       8    width of each entry; matches TX NUM_BITS (5-9)
//   DEPTH            16   number of entries; power of 2, >= 4
//   ALMOST_FULL_THR  12   almost_full_o asserted when level >= this value; 1..DEPTH
// PORTS
//   clk_i          in   1                    system clock; all logic on rising edge
//   rst_i          in   1                    synchronous, active-high reset
//   wr_en_i        in   1                    write request
//   wr_data_i      in   DATA_WIDTH           write data
//   full_o         out  1                    level == DEPTH
//   almost_full_o  out  1                    level >= ALMOST_FULL_THR
//   rd_en_i        in   1                    read request (pop)
//   rd_data_o      out  DATA_WIDTH           registered read data, valid the cycle after an accepted read
//   empty_o        out  1                    level == 0
//   level_o        out  $clog2(DEPTH)+1      current number of stored entries, 0..DEPTH
//   overflow_o     out  1                    sticky: write attempted while full
//   underflow_o    out  1                    sticky: read attempted while empty
//   clr_err_i      in   1                    clears overflow_o/underflow_o
// BEHAVIOUR
//   - Reset:
//       - wr_ptr = rd_ptr = 0, level_o = 0, empty_o = 1, full_o = 0, almost_full_o = 0.
//       - rd_data_o = 0, overflow_o = underflow_o = 0.
//       - Memory contents are not reset. Reset mid-operation discards all stored entries.
//   - Pointers are $clog2(DEPTH)+1 bits. The low bits address the memory.
//       - Both pointers wrap modulo 2*DEPTH; memory addressing wraps at DEPTH.
//   - Write accept: wr_acc = wr_en_i && !full_o.
//       - mem[wr_ptr] <= wr_data_i; wr_ptr increments.
//   - Read accept: rd_acc = rd_en_i && !empty_o.
//       - rd_data_o <= mem[rd_ptr] at that edge; rd_ptr increments.
//       - rd_data_o holds its value until the next accepted read.
//   - Read latency: 1 clock (rd_en_i at edge N, data on rd_data_o after edge N).
//   - Flags are decided from registered state only:
//       - A write while full is rejected even if a read is accepted in the same cycle.
//       - A read while empty is rejected even if a write is accepted in the same cycle.
//       - A write into an empty FIFO is poppable on the following cycle (empty_o deasserts one clock after the write).
//   - Level update:
//       - +1 on wr_acc only; -1 on rd_acc only.
//       - Unchanged when both or neither are accepted.
//   - full_o, empty_o and almost_full_o are decoded from the registered level (no combinational path from inputs).
//   - Error flags:
//       - overflow_o sets on wr_en_i && full_o; underflow_o sets on rd_en_i && empty_o.
//       - Both are cleared by clr_err_i.
//       - If set and clear coincide in the same cycle, set wins.
//   - Rejected operations change neither pointers, level nor rd_data_o.
//   - TX compatibility: the TX engine raises rd_en_i for one cycle while !empty_o. The byte it latches next cycle is rd_data_o.
// TESTING
//   1. Reset then idle:
//        -> empty_o=1, full_o=0, level_o=0, rd_data_o=0, flags=0.
//   2. Write 0xA5,0x3C, then read twice:
//        -> rd_data_o=0xA5 one cycle after first rd_en_i, then 0x3C.
//        -> level_o goes 2,1,0; empty_o=1 at end.
//   3. Fill 16 entries (0x00..0x0F):
//        -> almost_full_o=1 at level 12, full_o=1 at 16.
//        -> 17th write (0xFF) rejected, overflow_o=1.
//        -> Drain returns 0x00..0x0F in order.
//   4. Simultaneous wr/rd at level 5 for 40 cycles:
//        -> level_o stays 5; data order preserved across pointer wrap.
//   5. rd_en_i while empty:
//        -> underflow_o=1, rd_data_o unchanged.
//        -> clr_err_i clears it.
//        -> rd_en_i+clr_err_i together keeps underflow_o=1.
//   6. Write 3 bytes, assert rst_i for 1 cycle:
//        -> level_o=0, empty_o=1.
//        -> Subsequent write/read of 0x5A returns 0x5A.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO between client logic and the UART transmitter.
// Status flags are decoded from the registered level. Error flags are sticky until cleared.
module uart_tx_fifo #(
  parameter int DATA_WIDTH      = 8,
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_THR = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [DATA_WIDTH-1:0]      wr_data_i,
  output logic                       full_o,
  output logic                       almost_full_o,
  input  logic                       rd_en_i,
  output logic [DATA_WIDTH-1:0]      rd_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  input  logic                       clr_err_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]         wr_ptr_q;
  logic [LW-1:0]         rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full_o        = (level_q == LW'(DEPTH));
  assign empty_o       = (level_q == '0);
  assign almost_full_o = (level_q >= LW'(ALMOST_FULL_THR));
  assign level_o       = level_q;

  // Acceptance uses only registered flags, so a same-cycle pop never frees room for a push.
  assign wr_acc = wr_en_i && !full_o;
  assign rd_acc = rd_en_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_data_o   <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + LW'(1);
      end
      if (rd_acc) begin
        rd_data_o <= mem[rd_ptr_q[AW-1:0]];
        rd_ptr_q  <= rd_ptr_q + LW'(1);
      end
      if (wr_acc && !rd_acc) begin
        level_q <= level_q + LW'(1);
      end else if (rd_acc && !wr_acc) begin
        level_q <= level_q - LW'(1);
      end
      // Set has priority over clear.
      if (wr_en_i && full_o) begin
        overflow_o <= 1'b1;
      end else if (clr_err_i) begin
        overflow_o <= 1'b0;
      end
      if (rd_en_i && empty_o) begin
        underflow_o <= 1'b1;
      end else if (clr_err_i) begin
        underflow_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_uart_tx_fifo;

  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int THR = 12;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          wr_en_i = 1'b0;
  logic [DW-1:0] wr_data_i = '0;
  logic          rd_en_i = 1'b0;
  logic          clr_err_i = 1'b0;
  logic          full_o, almost_full_o, empty_o, overflow_o, underflow_o;
  logic [DW-1:0] rd_data_o;
  logic [4:0]    level_o;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rd;
  bit            m_ovf, m_unf;

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP), .ALMOST_FULL_THR(THR)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .full_o(full_o), .almost_full_o(almost_full_o),
    .rd_en_i(rd_en_i), .rd_data_o(rd_data_o),
    .empty_o(empty_o), .level_o(level_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o),
    .clr_err_i(clr_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_i) begin
    bit mfull, mempty;
    mfull  = (mq.size() == DEP);
    mempty = (mq.size() == 0);
    if (rst_i) begin
      mq.delete();
      m_rd  = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (rd_en_i && !mempty) m_rd = mq.pop_front();
      if (wr_en_i && !mfull) mq.push_back(wr_data_i);
      if (wr_en_i && mfull) m_ovf = 1'b1;
      else if (clr_err_i) m_ovf = 1'b0;
      if (rd_en_i && mempty) m_unf = 1'b1;
      else if (clr_err_i) m_unf = 1'b0;
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("m_level", 32'(level_o), 32'(mq.size()));
      chk("m_empty", 32'(empty_o), 32'(mq.size() == 0));
      chk("m_full", 32'(full_o), 32'(mq.size() == DEP));
      chk("m_afull", 32'(almost_full_o), 32'(mq.size() >= THR));
      chk("m_rdata", 32'(rd_data_o), 32'(m_rd));
      chk("m_ovf", 32'(overflow_o), 32'(m_ovf));
      chk("m_unf", 32'(underflow_o), 32'(m_unf));
    end
  end

  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    wr_en_i   = w;
    wr_data_i = d;
    rd_en_i   = r;
    clr_err_i = c;
    @(posedge clk_i);
    #1;
    wr_en_i   = 1'b0;
    rd_en_i   = 1'b0;
    clr_err_i = 1'b0;
  endtask

  initial begin
    // 1. reset then idle
    rst_i = 1'b1;
    step(0, 8'h00, 0, 0);
    chk_en = 1'b1;
    step(0, 8'h00, 0, 0);
    rst_i = 1'b0;
    step(0, 8'h00, 0, 0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_rdata", 32'(rd_data_o), 32'h00);
    chk("rst_flags", {30'd0, overflow_o, underflow_o}, 32'd0);

    // 2. two writes, two reads
    step(1, 8'hA5, 0, 0);
    step(1, 8'h3C, 0, 0);
    chk("t2_level2", 32'(level_o), 32'd2);
    step(0, 8'h00, 1, 0);
    chk("t2_rd0", 32'(rd_data_o), 32'hA5);
    chk("t2_level1", 32'(level_o), 32'd1);
    step(0, 8'h00, 1, 0);
    chk("t2_rd1", 32'(rd_data_o), 32'h3C);
    chk("t2_empty", 32'(empty_o), 32'd1);

    // 3. fill, overflow, write+read while full, drain
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0);
      if (i == 10) chk("t3_afull11", 32'(almost_full_o), 32'd0);
      if (i == 11) chk("t3_afull12", 32'(almost_full_o), 32'd1);
      if (i == 14) chk("t3_full15", 32'(full_o), 32'd0);
    end
    chk("t3_full16", 32'(full_o), 32'd1);
    step(1, 8'hFF, 0, 0);
    chk("t3_ovf", 32'(overflow_o), 32'd1);
    chk("t3_level16", 32'(level_o), 32'd16);
    step(1, 8'hEE, 1, 0);
    chk("t3_wrrd_full_rd", 32'(rd_data_o), 32'h00);
    chk("t3_wrrd_full_lvl", 32'(level_o), 32'd15);
    for (int i = 1; i < 16; i++) begin
      step(0, 8'h00, 1, 0);
      chk("t3_drain", 32'(rd_data_o), 32'(i));
    end
    chk("t3_empty", 32'(empty_o), 32'd1);
    step(0, 8'h00, 0, 1);
    chk("t3_ovf_clr", 32'(overflow_o), 32'd0);

    // 4. steady-state streaming at level 5 across pointer wrap
    for (int i = 0; i < 5; i++) step(1, 8'(8'h10 + i), 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 8'(8'h15 + i), 1, 0);
      chk("t4_stream", 32'(rd_data_o), 32'(8'h10 + i));
      chk("t4_level", 32'(level_o), 32'd5);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 1, 0);
      chk("t4_drain", 32'(rd_data_o), 32'(8'h38 + i));
    end

    // 5. underflow, clear, set-beats-clear, write+read while empty
    step(0, 8'h00, 1, 0);
    chk("t5_unf", 32'(underflow_o), 32'd1);
    chk("t5_rd_hold", 32'(rd_data_o), 32'h3C);
    step(0, 8'h00, 0, 1);
    chk("t5_unf_clr", 32'(underflow_o), 32'd0);
    step(0, 8'h00, 1, 1);
    chk("t5_set_wins", 32'(underflow_o), 32'd1);
    step(0, 8'h00, 0, 1);
    step(1, 8'h77, 1, 0);
    chk("t5_wrrd_empty_lvl", 32'(level_o), 32'd1);
    chk("t5_wrrd_empty_rd", 32'(rd_data_o), 32'h3C);
    chk("t5_wrrd_empty_unf", 32'(underflow_o), 32'd1);
    step(0, 8'h00, 1, 1);
    chk("t5_pop77", 32'(rd_data_o), 32'h77);
    chk("t5_unf_clr2", 32'(underflow_o), 32'd0);

    // 6. reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0, 0);
    rst_i = 1'b1;
    step(0, 8'h00, 0, 0);
    rst_i = 1'b0;
    chk("t6_level", 32'(level_o), 32'd0);
    chk("t6_empty", 32'(empty_o), 32'd1);
    chk("t6_rdata", 32'(rd_data_o), 32'h00);
    step(1, 8'h5A, 0, 0);
    step(0, 8'h00, 1, 0);
    chk("t6_5a", 32'(rd_data_o), 32'h5A);
    step(0, 8'h00, 0, 0);

    @(negedge clk_i);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
